// File: rtl/id_ex_control.sv
// Decodes the ID-stage opcode into the main control bundle and registers it as ID/EX.
// Latency: one cycle, ID inputs at edge T appear on ex_* after edge T+1. hazard_stall is combinational.
// Backpressure: stall_ext holds ID/EX; load-use hazards freeze PC/IF-ID and insert bubbles; flush wins.
//
// Ports:
//   clk, reset                     rising-edge clock, synchronous active-high reset
//   id_valid, id_opcode            ID instruction and its opcode instr[6:0]
//   id_rs1, id_rs2, id_rd          ID register fields
//   flush, stall_ext               kill the ID instruction / freeze ID/EX
//   ex_valid, ex_* controls        registered ID/EX control bundle
//   ex_alu_op, ex_rd, ex_illegal   registered ALUOp, destination, undecoded-opcode flag
//   hazard_stall                   freeze PC and IF/ID (combinational)
module id_ex_control #(
  parameter int unsigned ALUOP_W         = 2,
  parameter int unsigned ENABLE_JUMP     = 1,
  parameter int unsigned LOAD_USE_STALLS = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               id_valid,
  input  logic [6:0]         id_opcode,
  input  logic [4:0]         id_rs1,
  input  logic [4:0]         id_rs2,
  input  logic [4:0]         id_rd,
  input  logic               flush,
  input  logic               stall_ext,
  output logic               ex_valid,
  output logic               ex_branch,
  output logic               ex_jump,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_mem_to_reg,
  output logic               ex_reg_write,
  output logic               ex_alu_src,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic [4:0]         ex_rd,
  output logic               ex_illegal,
  output logic               hazard_stall
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [ALUOP_W-1:0] ALU_ADD = '0;
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_FUN = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_ILL = {ALUOP_W{1'b1}};

  // The counter holds the stall cycles still owed after the detect cycle.
  localparam logic [1:0] STALL_INIT = 2'(LOAD_USE_STALLS - 1);

  typedef struct packed {
    logic               branch;
    logic               jump;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               reg_write;
    logic               alu_src;
    logic [ALUOP_W-1:0] alu_op;
    logic               illegal;
  } ctl_t;

  ctl_t       dec;
  logic       uses_rs1;
  logic       uses_rs2;
  logic       is_ill;
  logic       jump_ok;
  logic       detect;

  ctl_t       ctl_q, ctl_d;
  logic       valid_q, valid_d;
  logic [4:0] rd_q, rd_d;
  logic [1:0] cnt_q, cnt_d;

  assign jump_ok = (ENABLE_JUMP != 0);

  // Opcode decode
  always_comb begin
    dec      = '0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    is_ill   = 1'b0;
    case (id_opcode)
      OP_R: begin
        dec.reg_write = 1'b1; dec.alu_op = ALU_FUN;
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
      end
      OP_I: begin
        dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_op = ALU_FUN;
        uses_rs1 = 1'b1;
      end
      OP_LOAD: begin
        dec.mem_read = 1'b1; dec.mem_to_reg = 1'b1; dec.reg_write = 1'b1;
        dec.alu_src = 1'b1; dec.alu_op = ALU_ADD;
        uses_rs1 = 1'b1;
      end
      OP_STORE: begin
        dec.alu_src = 1'b1; dec.mem_write = 1'b1; dec.alu_op = ALU_ADD;
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        dec.branch = 1'b1; dec.alu_op = ALU_SUB;
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
      end
      OP_JAL: begin
        dec.jump = 1'b1; dec.reg_write = 1'b1; dec.alu_op = ALU_ADD;
        is_ill = ~jump_ok;
      end
      OP_JALR: begin
        dec.jump = 1'b1; dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.alu_op = ALU_ADD;
        uses_rs1 = 1'b1;
        is_ill = ~jump_ok;
      end
      OP_LUI: begin
        dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.alu_op = ALU_ADD;
        is_ill = ~jump_ok;
      end
      default: is_ill = 1'b1;
    endcase
    // An undecoded opcode reads no registers, so it can never trigger a hazard.
    if (is_ill) begin
      dec         = '0;
      dec.alu_op  = ALU_ILL;
      dec.illegal = 1'b1;
      uses_rs1    = 1'b0;
      uses_rs2    = 1'b0;
    end
  end

  assign detect = id_valid & valid_q & ctl_q.mem_read & (rd_q != 5'd0) &
                  (((rd_q == id_rs1) & uses_rs1) | ((rd_q == id_rs2) & uses_rs2));

  assign hazard_stall = ~flush & (detect | (cnt_q != 2'd0));

  // ID/EX next state: flush > stall_ext (hold) > hazard bubble > load
  always_comb begin
    ctl_d   = ctl_q;
    valid_d = valid_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (flush) begin
      ctl_d = '0; valid_d = 1'b0; rd_d = 5'd0; cnt_d = 2'd0;
    end else if (!stall_ext) begin
      if (hazard_stall) begin
        ctl_d = '0; valid_d = 1'b0; rd_d = 5'd0;
        cnt_d = (cnt_q == 2'd0) ? STALL_INIT : cnt_q - 2'd1;
      end else if (id_valid) begin
        ctl_d = dec; valid_d = 1'b1; rd_d = id_rd;
      end else begin
        ctl_d = '0; valid_d = 1'b0; rd_d = 5'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctl_q   <= '0;
      valid_q <= 1'b0;
      rd_q    <= 5'd0;
      cnt_q   <= 2'd0;
    end else begin
      ctl_q   <= ctl_d;
      valid_q <= valid_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_branch     = ctl_q.branch;
  assign ex_jump       = ctl_q.jump;
  assign ex_mem_read   = ctl_q.mem_read;
  assign ex_mem_write  = ctl_q.mem_write;
  assign ex_mem_to_reg = ctl_q.mem_to_reg;
  assign ex_reg_write  = ctl_q.reg_write;
  assign ex_alu_src    = ctl_q.alu_src;
  assign ex_alu_op     = ctl_q.alu_op;
  assign ex_rd         = rd_q;
  assign ex_illegal    = ctl_q.illegal;

endmodule

// File: doc/id_ex_control.md
# id_ex_control

Parametrised pipelined main-control unit for the 5-stage RISC-V core. It decodes the ID-stage opcode into the control bundle (Branch, Jump, MemRead, MemWrite, MemToReg, RegWrite, ALUSrc, ALUOp) and registers it as the ID/EX control register. It also detects load-use hazards and holds the front end for a configurable number of cycles while inserting bubbles. External stall and branch flush are applied here. It sits between the IF/ID register and the EX stage, driving PC/IF-ID freeze and the EX/MEM control path.

## Interface
- ALUOP_W, 2: ALUOp width, ≥2; codes are zero-extended to this width.
- ENABLE_JUMP, 1: 1 decodes JAL/JALR/LUI; 0 treats them as illegal.
- LOAD_USE_STALLS, 1: bubbles inserted per load-use hazard, 1..3.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  ID-stage instruction is valid
- id_opcode  in  7  instr[6:0]
- id_rs1, id_rs2, id_rd  in  5 each  register fields of the ID instruction
- flush  in  1  branch/jump taken; kill the ID instruction
- stall_ext  in  1  downstream freeze; hold ID/EX
- ex_valid  out  1  ID/EX holds a real instruction
- ex_branch, ex_jump, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_alu_src  out  1 each  registered controls
- ex_alu_op  out  ALUOP_W  registered ALUOp
- ex_rd  out  5  registered destination register
- ex_illegal  out  1  ID/EX instruction had an undecoded opcode
- hazard_stall  out  1  combinational; freeze PC and IF/ID

## Operation
- Decode is combinational. Unlisted controls are 0. ALUOp codes: 00 add, 01 sub, 10 funct-decoded, all-ones illegal.
  - R 0110011: reg_write, alu_op 10.
  - I 0010011: alu_src, reg_write, alu_op 10.
  - Load 0000011: mem_read, mem_to_reg, reg_write, alu_src, alu_op 00.
  - Store 0100011: alu_src, mem_write, alu_op 00.
  - Branch 1100011: branch, alu_op 01.
  - JAL 1101111: jump, reg_write, alu_op 00.
  - JALR 1100111: jump, reg_write, alu_src, alu_op 00.
  - LUI 0110111: reg_write, alu_src, alu_op 00.
  - Any other opcode, and the last three when ENABLE_JUMP=0: all controls 0, alu_op all-ones, illegal=1.
- Register-read usage:
  - uses_rs1: R, I, load, store, branch, JALR.
  - uses_rs2: R, store, branch.
- Load-use detect (combinational) requires all of:
  - id_valid & ex_valid & ex_mem_read & ex_rd≠0;
  - (ex_rd==id_rs1 & uses_rs1) | (ex_rd==id_rs2 & uses_rs2).
- Stall counter cnt (2 bits), two states:
  - IDLE (cnt==0): on detect, load cnt ← LOAD_USE_STALLS−1.
  - STALL (cnt≠0): decrement each unfrozen cycle.
- hazard_stall = ~flush & (detect | cnt≠0).
- A bubble is all controls 0, ex_valid 0, ex_illegal 0, ex_rd 0, alu_op 0.
- ID/EX update priority per edge:
  1. reset: bubble, cnt←0.
  2. flush: bubble, cnt←0.
  3. stall_ext: hold ID/EX and cnt unchanged.
  4. hazard_stall: bubble; cnt loads or decrements as above.
  5. Otherwise: load the decoded bundle; ex_valid←id_valid. When id_valid=0, all controls load as 0.
- ex_illegal is set only when id_valid=1.

## Timing
- Reset: every registered output is 0 and cnt=0, so hazard_stall=0 the cycle after reset.
- Latency: the ID instruction at edge T appears on ex_* after edge T+1.
- Load-use: exactly LOAD_USE_STALLS consecutive unfrozen cycles with hazard_stall=1 and bubbles in EX. The dependent instruction enters ID/EX on the following edge.
- stall_ext during a stall: the count pauses and resumes; total bubble count is unchanged.
- flush during a stall: the stall aborts at once and hazard_stall=0 in that cycle.
- flush together with stall_ext: flush wins.
- Reset mid-stall: cnt clears and there are no further stall cycles.
- ex_rd==0 never causes a stall.

## Test plan
- Decode sweep: each of the 8 opcodes plus 7'b1111111 with id_valid=1. Check the ex_* bundle one cycle later matches the listed encoding, e.g. load → mem_read=mem_to_reg=reg_write=alu_src=1, alu_op=00; illegal → alu_op=11, ex_illegal=1.
- ENABLE_JUMP=0: JAL → ex_illegal=1, ex_jump=0, ex_reg_write=0.
- Load-use, LOAD_USE_STALLS=1: lw x5, then add x6,x5,x7. Check hazard_stall=1 for one cycle, one bubble (ex_valid=0), and the add reaches EX after that. Repeat with LOAD_USE_STALLS=3: three consecutive bubbles. With rd=x0: no stall.
- Load followed by a store using the load result as rs2 → stall; followed by LUI writing the same rd (no rs use) → no stall.
- Stall interaction, LOAD_USE_STALLS=3:
  - stall_ext asserted for 2 cycles in the middle of a hazard: ID/EX holds, and 3 bubbles total are still produced.
  - flush in the 2nd stall cycle: hazard_stall=0 that cycle and the next ID/EX is a bubble.
- Reset asserted mid-stall with ex_* loaded: all outputs 0 the next cycle, and hazard_stall=0.
